// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle RV32I-subset control unit:
// state encoding, opcode constants, ALU control codes and mux select codes.
package multicycle_control_fsm_pkg;

  // State encoding
  localparam logic [3:0] ENC_FETCH     = 4'd0;
  localparam logic [3:0] ENC_DECODE    = 4'd1;
  localparam logic [3:0] ENC_MEM_ADDR  = 4'd2;
  localparam logic [3:0] ENC_MEM_READ  = 4'd3;
  localparam logic [3:0] ENC_MEM_WB    = 4'd4;
  localparam logic [3:0] ENC_MEM_WRITE = 4'd5;
  localparam logic [3:0] ENC_EXEC_R    = 4'd6;
  localparam logic [3:0] ENC_EXEC_I    = 4'd7;
  localparam logic [3:0] ENC_ALU_WB    = 4'd8;
  localparam logic [3:0] ENC_BRANCH    = 4'd9;
  localparam logic [3:0] ENC_BR_NT     = 4'd10;
  localparam logic [3:0] ENC_HALT      = 4'd11;

  typedef enum logic [3:0] {
    ST_FETCH     = ENC_FETCH,
    ST_DECODE    = ENC_DECODE,
    ST_MEM_ADDR  = ENC_MEM_ADDR,
    ST_MEM_READ  = ENC_MEM_READ,
    ST_MEM_WB    = ENC_MEM_WB,
    ST_MEM_WRITE = ENC_MEM_WRITE,
    ST_EXEC_R    = ENC_EXEC_R,
    ST_EXEC_I    = ENC_EXEC_I,
    ST_ALU_WB    = ENC_ALU_WB,
    ST_BRANCH    = ENC_BRANCH,
    ST_BR_NT     = ENC_BR_NT,
    ST_HALT      = ENC_HALT
  } state_e;

  // Opcodes (IR[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // ALU operation class handed to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // True for a state whose exit completes an instruction. BRANCH only
  // completes when the branch is taken; otherwise BR_NT finishes it.
  function automatic logic is_retiring(input state_e s, input logic zero);
    logic r;
    case (s)
      ST_MEM_WB, ST_MEM_WRITE, ST_ALU_WB, ST_BR_NT: r = 1'b1;
      ST_BRANCH:                                    r = zero;
      default:                                      r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_alu_decoder.sv
// ALU decoder: maps (ALUOp, funct3, funct7_5) to an ALU control code.
// The illegal flag reports R-type funct combinations this core cannot
// execute; it is evaluated regardless of ALUOp so DECODE can use it.
module multicycle_control_fsm_alu_decoder
  import multicycle_control_fsm_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_control,
  output logic       illegal
);

  logic [3:0] funct_ctrl_s;

  // Decode the R-type funct fields into an ALU operation and legality flag
  always_comb begin
    funct_ctrl_s = ALU_ADD;
    illegal      = 1'b0;
    case ({funct3, funct7_5})
      4'b0000: funct_ctrl_s = ALU_ADD;
      4'b0001: funct_ctrl_s = ALU_SUB;
      4'b1110: funct_ctrl_s = ALU_AND;
      4'b1100: funct_ctrl_s = ALU_OR;
      default: begin
        funct_ctrl_s = ALU_ADD;
        illegal      = 1'b1;
      end
    endcase
  end

  // Select the final ALU control code from the operation class
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:   alu_control = ALU_ADD;
      ALUOP_SUB:   alu_control = ALU_SUB;
      ALUOP_FUNCT: alu_control = funct_ctrl_s;
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Control unit for the multicycle RV32I-subset datapath. One state per
// cycle; outputs are decoded from the current state (PCWrite in BRANCH
// also follows zero). Keeps a count of retired instructions.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic             zero,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             PCSource,
  output logic             RegWrite,
  output logic [3:0]       ALUControl,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [1:0]       alu_op_s;
  logic [3:0]       alu_ctrl_s;
  logic             funct_illegal_s;
  logic             pc4_s;

  // Operation class for the ALU decoder in the current state
  always_comb begin
    alu_op_s = ALUOP_ADD;
    case (state_q)
      ST_EXEC_R: alu_op_s = ALUOP_FUNCT;
      ST_BRANCH: alu_op_s = ALUOP_SUB;
      default:   alu_op_s = ALUOP_ADD;
    endcase
  end

  multicycle_control_fsm_alu_decoder u_alu_decoder (
    .alu_op      (alu_op_s),
    .funct3      (funct3),
    .funct7_5    (funct7_5),
    .alu_control (alu_ctrl_s),
    .illegal     (funct_illegal_s)
  );

  // Next-state sequencing and retired-instruction counting
  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    if (reset) begin
      state_d   = ST_FETCH;
      retired_d = '0;
    end else begin
      case (state_q)
        ST_FETCH:  state_d = ST_DECODE;
        ST_DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state_d = ST_MEM_ADDR;
            OP_R:      state_d = funct_illegal_s ? ST_HALT : ST_EXEC_R;
            OP_IMM:    state_d = (funct3 == 3'b000) ? ST_EXEC_I : ST_HALT;
            OP_BRANCH: state_d = (funct3 == 3'b000) ? ST_BRANCH : ST_HALT;
            default:   state_d = ST_HALT;
          endcase
        end
        ST_MEM_ADDR:  state_d = (opcode == OP_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
        ST_MEM_READ:  state_d = ST_MEM_WB;
        ST_MEM_WB:    state_d = ST_FETCH;
        ST_MEM_WRITE: state_d = ST_FETCH;
        ST_EXEC_R:    state_d = ST_ALU_WB;
        ST_EXEC_I:    state_d = ST_ALU_WB;
        ST_ALU_WB:    state_d = ST_FETCH;
        ST_BRANCH:    state_d = zero ? ST_FETCH : ST_BR_NT;
        ST_BR_NT:     state_d = ST_FETCH;
        ST_HALT:      state_d = ST_HALT;
        default:      state_d = ST_HALT;
      endcase
      if (is_retiring(state_q, zero)) begin
        retired_d = retired_q + CNT_W'(1);
      end else begin
        retired_d = retired_q;
      end
    end
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    retired_q <= retired_d;
  end

  // Output decode; every terminal state except taken BRANCH adds PC+4
  always_comb begin
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    MemtoReg   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REG;
    PCSource   = 1'b0;
    RegWrite   = 1'b0;
    ALUControl = 4'b0000;
    halted     = 1'b0;
    pc4_s      = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
        end
        ST_DECODE: begin
          ALUSrcB    = SRCB_IMM;
          ALUControl = ALU_ADD;
        end
        ST_MEM_ADDR, ST_EXEC_I: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_IMM;
          ALUControl = ALU_ADD;
        end
        ST_MEM_READ: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        ST_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
          pc4_s    = 1'b1;
        end
        ST_MEM_WRITE: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
          pc4_s    = 1'b1;
        end
        ST_EXEC_R: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_REG;
          ALUControl = alu_ctrl_s;
        end
        ST_ALU_WB: begin
          RegWrite = 1'b1;
          pc4_s    = 1'b1;
        end
        ST_BRANCH: begin
          ALUSrcA    = 1'b1;
          ALUSrcB    = SRCB_REG;
          ALUControl = alu_ctrl_s;
          PCSource   = 1'b1;
          PCWrite    = zero;
        end
        ST_BR_NT: pc4_s  = 1'b1;
        ST_HALT:  halted = 1'b1;
        default:  halted = 1'b1;
      endcase
      if (pc4_s) begin
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_FOUR;
        ALUControl = ALU_ADD;
        PCSource   = 1'b0;
        PCWrite    = 1'b1;
      end else begin
        pc4_s = 1'b0;
      end
    end else begin
      pc4_s = 1'b0;
    end
  end

  // Counter is forced to zero while reset is held, even before the first edge
  assign retired = reset ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: directed scenarios plus
// random instruction streams judged against a per-instruction model that
// predicts cycle count and how often each enable fires.
module tb_multicycle_control_fsm;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_ADDI = 3, K_BEQ = 4, K_ILL = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        zero;
  logic        PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic        PCSource, RegWrite, halted;
  logic [3:0]  ALUControl;
  logic [31:0] retired;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  logic [31:0] exp_retired = 32'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7_5(funct7_5), .zero(zero), .PCWrite(PCWrite), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .RegWrite(RegWrite), .ALUControl(ALUControl),
    .halted(halted), .retired(retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // R-type ALU code from the instruction set table; 4'hF marks illegal
  function automatic logic [3:0] r_alu(input logic [2:0] f3, input logic f7);
    if (f3 == 3'd0) return f7 ? 4'b0110 : 4'b0010;
    if (f3 == 3'd7 && !f7) return 4'b0000;
    if (f3 == 3'd6 && !f7) return 4'b0001;
    return 4'hF;
  endfunction

  function automatic int classify(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    if (op == 7'b0000011) return K_LW;
    if (op == 7'b0100011) return K_SW;
    if (op == 7'b0110011) return (r_alu(f3, f7) == 4'hF) ? K_ILL : K_R;
    if (op == 7'b0010011) return (f3 == 3'd0) ? K_ADDI : K_ILL;
    if (op == 7'b1100011) return (f3 == 3'd0) ? K_BEQ : K_ILL;
    return K_ILL;
  endfunction

  function automatic logic [16:0] all_outs();
    return {PCWrite, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA,
            ALUSrcB, PCSource, RegWrite, ALUControl, halted};
  endfunction

  // Hold reset for three edges; leaves time at posedge+1 of cycle 1
  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", 32'(all_outs()), 32'd0);
    check("reset_retired", retired, 32'd0);
    reset = 1'b0;
    exp_retired = 32'd0;
  endtask

  // Entered at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
    int         kind, cpi, n_mr, n_mw, n_rw, n_pw, n_ex;
    logic       pcs, mtr, iord_mw;
    logic [3:0] alu_ex, exp_alu;
    opcode = op; funct3 = f3; funct7_5 = f7; zero = z;
    kind = classify(op, f3, f7);
    #1;
    check("fetch", 32'({MemRead, IRWrite, IorD, PCWrite, halted}), 32'b11000);
    check("retired_at_fetch", retired, exp_retired);
    @(posedge clk); #1;
    check("decode", 32'({ALUSrcA, ALUSrcB, ALUControl, PCWrite, MemRead}), 32'({1'b0, 2'b10, 4'b0010, 1'b0, 1'b0}));
    if (kind == K_ILL) begin
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
        check("halt_quiet", 32'({halted, PCWrite, MemWrite, RegWrite, MemRead, IRWrite}), 32'b100000);
        check("halt_retired", retired, exp_retired);
        @(posedge clk); #1;
      end
      do_reset();
      return;
    end
    case (kind)
      K_LW:    cpi = 5;
      K_BEQ:   cpi = z ? 3 : 4;
      default: cpi = 4;
    endcase
    n_mr = 1; n_mw = 0; n_rw = 0; n_pw = 0; n_ex = 0;
    pcs = 1'b0; mtr = 1'b0; iord_mw = 1'b0; alu_ex = 4'h0;
    for (int c = 3; c <= cpi; c++) begin
      @(posedge clk); #1;
      if (MemRead)  n_mr++;
      if (MemWrite) begin n_mw++; iord_mw = IorD; end
      if (RegWrite) begin n_rw++; mtr = MemtoReg; end
      if (PCWrite)  begin n_pw++; pcs = PCSource; end
      if (ALUSrcA && ALUSrcB == 2'b00) begin n_ex++; alu_ex = ALUControl; end
    end
    @(posedge clk); #1;
    exp_retired = exp_retired + 32'd1;
    check("retired_after", retired, exp_retired);
    check("n_memread", n_mr, (kind == K_LW) ? 2 : 1);
    check("n_memwrite", n_mw, (kind == K_SW) ? 1 : 0);
    check("n_regwrite", n_rw, (kind == K_LW || kind == K_R || kind == K_ADDI) ? 1 : 0);
    check("n_pcwrite", n_pw, 1);
    check("pcsource", 32'(pcs), 32'(kind == K_BEQ && z));
    if (kind == K_SW) check("iord_on_store", 32'(iord_mw), 32'd1);
    if (n_rw != 0) check("memtoreg", 32'(mtr), 32'(kind == K_LW));
    check("n_exec", n_ex, (kind == K_R || kind == K_BEQ) ? 1 : 0);
    if (kind == K_R || kind == K_BEQ) begin
      exp_alu = (kind == K_BEQ) ? 4'b0110 : r_alu(f3, f7);
      check("alu_exec", 32'(alu_ex), 32'(exp_alu));
    end
  endtask

  initial begin
    int start_cyc, r, sel;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    opcode = 7'd0; funct3 = 3'd0; funct7_5 = 1'b0; zero = 1'b0;
    do_reset();

    // Boot program: addi, lw, add, sub, and -> 21 cycles, 5 retired
    start_cyc = cyc;
    run_instr(7'b0010011, 3'b000, 1'b0, 1'b0);
    run_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    run_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
    run_instr(7'b0110011, 3'b000, 1'b1, 1'b1);
    run_instr(7'b0110011, 3'b111, 1'b0, 1'b0);
    check("boot_cycles", cyc - start_cyc, 21);
    check("boot_retired", retired, 32'd5);

    run_instr(7'b1100011, 3'b000, 1'b0, 1'b1); // beq taken
    run_instr(7'b1100011, 3'b000, 1'b0, 1'b0); // beq not taken
    run_instr(7'b0100011, 3'b010, 1'b0, 1'b1); // sw
    run_instr(7'b0000000, 3'b000, 1'b0, 1'b0); // all-zero word halts
    run_instr(7'b0110011, 3'b001, 1'b0, 1'b0); // illegal R funct halts

    // Reset while in MEM_READ abandons the load
    opcode = 7'b0000011; funct3 = 3'b010; funct7_5 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mem_read_state", 32'({MemRead, IorD, RegWrite}), 32'b110);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_outs", 32'(all_outs()), 32'd0);
    reset = 1'b0;
    #1;
    check("midreset_fetch", 32'({MemRead, IRWrite, RegWrite}), 32'b110);
    check("midreset_retired", retired, 32'd0);
    #1;
    exp_retired = 32'd0;
    @(posedge clk); #1;
    check("midreset_decode", 32'({RegWrite, ALUSrcB}), 32'b010);
    @(posedge clk); #1;  // MEM_ADDR of the restarted load
    repeat (3) @(posedge clk);
    #1;
    check("restart_retired", retired, 32'd1);
    exp_retired = 32'd1;

    // Random instruction stream
    for (int n = 0; n < 250; n++) begin
      r  = $urandom_range(0, 9);
      f3 = 3'($urandom);
      f7 = 1'($urandom);
      case (r)
        0, 1: op = 7'b0000011;
        2:    op = 7'b0100011;
        3, 4: begin
          op  = 7'b0110011;
          sel = $urandom_range(0, 4);
          if (sel == 0) begin f3 = 3'b000; f7 = 1'b0; end
          else if (sel == 1) begin f3 = 3'b000; f7 = 1'b1; end
          else if (sel == 2) begin f3 = 3'b111; f7 = 1'b0; end
          else if (sel == 3) begin f3 = 3'b110; f7 = 1'b0; end
        end
        5: begin op = 7'b0010011; if ($urandom_range(0, 3) != 0) f3 = 3'b000; end
        6, 7: begin op = 7'b1100011; if ($urandom_range(0, 3) != 0) f3 = 3'b000; end
        default: op = 7'($urandom);
      endcase
      run_instr(op, f3, f7, 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
